// File: rtl/systolic_pkg.sv
// Shared types for the output-stationary systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    ModeBool = 2'd0,
    ModeMac  = 2'd1,
    ModeSat  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    StLoad,
    StDrain,
    StRead
  } state_t;

  // The reserved encoding behaves as MAC.
  function automatic mode_t decode_mode(logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd0:    m = ModeBool;
      2'd2:    m = ModeSat;
      default: m = ModeMac;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/systolic_matmul_array_if.sv
// Beat input stream and row output stream of the systolic matrix multiplier.
interface systolic_matmul_array_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 16
);

  logic [1:0]           mode;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [N*W-1:0]       in_a;
  logic [N*W-1:0]       in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [$clog2(N)-1:0] out_row;
  logic [N*ACC_W-1:0]   out_data;

  modport slave (
    input  mode, in_valid, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out_row, out_data
  );

  modport master (
    output mode, in_valid, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_row, out_data
  );

endinterface

// File: rtl/systolic_pe.sv
// One processing element: A/B pass registers plus an accumulator that either
// accumulates in the latched mode or shifts in the accumulator from the PE above.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_t            mode_i,
  input  logic             shift,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [ACC_W-1:0] acc_in,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic [ACC_W-1:0] acc_out
);

  logic [W-1:0]     a_q, b_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2*W-1:0]   prod;
  logic [ACC_W:0]   sum;
  logic             hit;

  always_comb begin
    prod  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    sum   = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    hit   = (a_i != '0) && (b_i != '0);
    acc_d = acc_q;
    if (shift) begin
      acc_d = acc_in;
    end else begin
      case (mode_i)
        ModeBool: acc_d = {{(ACC_W - 1){1'b0}}, acc_q[0] | hit};
        // Extra carry bit detects overflow before clamping.
        ModeSat:  acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        default:  acc_d = sum[ACC_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign acc_out = acc_q;

endmodule

// File: rtl/systolic_matmul_array.sv
// N x N output-stationary systolic multiplier: skewed A/B injection, drain, then
// row-by-row readout through the accumulator shift chain under ready/valid.
module systolic_matmul_array
  import systolic_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 16
) (
  input logic                     clk,
  input logic                     reset,
  systolic_matmul_array_if.slave  bus
);

  localparam int unsigned RowW = $clog2(N);
  localparam int unsigned CntW = $clog2(2 * N);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RowW-1:0] row_q, row_d;
  mode_t           mode_q, mode_d;
  logic            first_q, first_d;

  logic in_ready;
  logic accept;
  logic xfer;

  assign in_ready = (state_q == StLoad);
  assign accept   = bus.in_valid & in_ready;
  assign xfer     = (state_q == StRead) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    mode_d  = mode_q;
    first_d = first_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (first_q) begin
            mode_d = decode_mode(bus.mode);
          end
          // The beat after a final beat opens a new matrix.
          first_d = bus.in_last;
          if (bus.in_last) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(2 * N - 2)) begin
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRead: begin
        if (xfer) begin
          if (row_q == '0) begin
            state_d = StLoad;
            row_d   = RowW'(N - 1);
          end else begin
            row_d = row_q - RowW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      row_q   <= RowW'(N - 1);
      mode_q  <= ModeMac;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      first_q <= first_d;
    end
  end

  logic [W-1:0]     a_h   [N][N+1];
  logic [W-1:0]     b_v   [N+1][N];
  logic [ACC_W-1:0] acc_v [N+1][N];

  // Row i of A and column i of B pass through i+1 registers; non-beat cycles inject zero.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [W-1:0] a_sk_q [i+1];
    logic [W-1:0] b_sk_q [i+1];
    logic         unused_edge;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d <= i; d++) begin
          a_sk_q[d] <= '0;
          b_sk_q[d] <= '0;
        end
      end else begin
        a_sk_q[0] <= accept ? bus.in_a[i*W +: W] : '0;
        b_sk_q[0] <= accept ? bus.in_b[i*W +: W] : '0;
        for (int d = 1; d <= i; d++) begin
          a_sk_q[d] <= a_sk_q[d-1];
          b_sk_q[d] <= b_sk_q[d-1];
        end
      end
    end

    assign a_h[i][0]   = a_sk_q[i];
    assign b_v[0][i]   = b_sk_q[i];
    assign acc_v[0][i] = '0;
    assign unused_edge = ^{a_h[i][N], b_v[N][i]};
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .W     (W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .mode_i  (mode_q),
        .shift   (xfer),
        .a_i     (a_h[i][j]),
        .b_i     (b_v[i][j]),
        .acc_in  (acc_v[i][j]),
        .a_o     (a_h[i][j+1]),
        .b_o     (b_v[i+1][j]),
        .acc_out (acc_v[i+1][j])
      );
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign bus.out_data[j*ACC_W +: ACC_W] = acc_v[N][j];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StRead);
  assign bus.out_row   = row_q;

endmodule

// File: tb/tb_systolic_matmul_array.sv
// Directed bench for systolic_matmul_array with a matrix-level reference model.
module tb_systolic_matmul_array;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned ACC_W = 8;
  localparam int          AccMax = (1 << ACC_W) - 1;
  localparam int          MaxBeats = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  systolic_matmul_array_if #(.N(N), .W(W), .ACC_W(ACC_W)) bus ();

  systolic_matmul_array #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int beat_a [MaxBeats][N];
  int beat_b [MaxBeats][N];
  int exp_c  [N][N];
  int got_c  [N][N];

  bit busy = 1'b0;
  int t_last = 0;
  int xfer_cnt = 0;
  int rows_done = 0;
  bit ready_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Every cycle: handshake flags follow matrix progress, and any presented row matches C.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      busy     = 1'b0;
      xfer_cnt = 0;
    end else begin
      chk("in_ready", bus.in_ready, !busy);
      chk("out_valid", bus.out_valid, busy && (cyc - t_last >= 2 * N));
      if (bus.out_valid === 1'b1) begin
        chk("out_row", bus.out_row, N - 1 - xfer_cnt);
        for (int j = 0; j < N; j++) begin
          chk("out_data", bus.out_data[j*ACC_W +: ACC_W], exp_c[N-1-xfer_cnt][j]);
        end
        if (bus.out_ready === 1'b1) begin
          for (int j = 0; j < N; j++) begin
            got_c[N-1-xfer_cnt][j] = int'(bus.out_data[j*ACC_W +: ACC_W]);
          end
          xfer_cnt++;
          if (xfer_cnt == N) begin
            xfer_cnt = 0;
            busy     = 1'b0;
            rows_done++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready && bus.in_last) begin
        busy   = 1'b1;
        t_last = cyc;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_toggle ? (cyc % 3 == 0) : 1'b1;
    end
  end

  task automatic compute_model(input int nb, input logic [1:0] m0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        bit     o = 1'b0;
        for (int k = 0; k < nb; k++) begin
          s += beat_a[k][i] * beat_b[k][j];
          if (beat_a[k][i] != 0 && beat_b[k][j] != 0) o = 1'b1;
        end
        if (m0 == 2'd0)      exp_c[i][j] = int'(o);
        else if (m0 == 2'd2) exp_c[i][j] = (s > AccMax) ? AccMax : int'(s);
        else                 exp_c[i][j] = int'(s % (AccMax + 1));
      end
    end
  endtask

  task automatic send_matrix(input int nb, input logic [1:0] m0, input logic [1:0] m1,
                             input bit gaps, input int junk);
    int k = 0;
    while (k < nb) begin
      bit gap;
      gap = gaps && ($urandom_range(1, 0) == 1);
      bus.mode = (k == 0) ? m0 : m1;
      if (gap) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(1, 0));
        bus.in_a     = (N * W)'($urandom);
        bus.in_b     = (N * W)'($urandom);
      end else begin
        for (int i = 0; i < N; i++) begin
          bus.in_a[i*W +: W] = W'(beat_a[k][i]);
          bus.in_b[i*W +: W] = W'(beat_b[k][i]);
        end
        bus.in_valid = 1'b1;
        bus.in_last  = (k == nb - 1);
      end
      @(posedge clk);
      #1;
      if (!gap) k++;
    end
    compute_model(nb, m0);
    for (int c = 0; c < junk; c++) begin
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      bus.in_a     = (N * W)'($urandom);
      bus.in_b     = (N * W)'($urandom);
      bus.mode     = 2'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    int n;
    start = rows_done;
    n = 0;
    while (rows_done == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, rows_done - start, 1);
    #1;
  endtask

  task automatic fill(input int nb, input int av, input int bv);
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < N; i++) begin
        beat_a[k][i] = av;
        beat_b[k][i] = bv;
      end
    end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        beat_a[k][i] = (i == k) ? 1 : 0;
        beat_b[k][i] = (k == 3 && i == 3) ? 0 : 4 * k + i + 1;
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_in_ready"}, bus.in_ready, 1);
    chk({name, "_out_valid"}, bus.out_valid, 0);
    chk({name, "_out_row"}, bus.out_row, 3);
    chk({name, "_out_data"}, bus.out_data, 0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.mode     = 2'd1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values("reset");

    // Identity A: C equals B; junk beats during DRAIN must be ignored.
    fill_identity();
    send_matrix(4, 2'd1, 2'd1, 1'b0, 5);
    wait_done("identity_done");
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        chk("pin_identity", got_c[r][j], (r == 3 && j == 3) ? 0 : 4 * r + j + 1);
      end
    end

    // BOOL: only b[2][1] nonzero; mode change after first beat is ignored.
    fill(4, 5, 0);
    beat_b[2][1] = 3;
    send_matrix(4, 2'd0, 2'd2, 1'b0, 0);
    wait_done("bool_done");
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        chk("pin_bool", got_c[r][j], (j == 1) ? 1 : 0);
      end
    end

    // SAT clamps 1125 to 255.
    fill(5, 15, 15);
    send_matrix(5, 2'd2, 2'd1, 1'b0, 0);
    wait_done("sat_done");
    chk("pin_sat_00", got_c[0][0], 255);
    chk("pin_sat_33", got_c[3][3], 255);
    chk("pin_sat_21", got_c[2][1], 255);

    // Reserved mode acts as MAC: 1125 mod 256 = 101.
    send_matrix(5, 2'd3, 2'd2, 1'b0, 0);
    wait_done("mac_done");
    chk("pin_mac_00", got_c[0][0], 101);
    chk("pin_mac_32", got_c[3][2], 101);

    // Gapped delivery of the identity matrix gives the same C.
    fill_identity();
    send_matrix(4, 2'd1, 2'd0, 1'b1, 0);
    wait_done("gaps_done");
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        chk("pin_gaps", got_c[r][j], (r == 3 && j == 3) ? 0 : 4 * r + j + 1);
      end
    end

    // Random operands with a throttled consumer.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        beat_a[k][i] = int'($urandom_range(15, 0));
        beat_b[k][i] = int'($urandom_range(15, 0));
      end
    end
    ready_toggle = 1'b1;
    send_matrix(6, 2'd1, 2'd1, 1'b1, 0);
    wait_done("throttle_done");
    ready_toggle = 1'b0;

    // Single-beat matrix right after: accumulators must start from zero.
    fill(1, 1, 3);
    send_matrix(1, 2'd1, 2'd1, 1'b0, 0);
    wait_done("single_done");
    chk("pin_single_00", got_c[0][0], 3);
    chk("pin_single_31", got_c[3][1], 3);

    // Abort in DRAIN cycle 3, then a 1-beat matrix with A = B = 2.
    fill(3, 9, 7);
    send_matrix(3, 2'd1, 2'd1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values("abort");
    fill(1, 2, 2);
    send_matrix(1, 2'd1, 2'd1, 1'b0, 0);
    wait_done("after_abort_done");
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        chk("pin_after_abort", got_c[r][j], 4);
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
